shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
//  - Arbitrates one single-port shared data memory between core 0, core 1 and the host programming port.
//  - Sits between multicore_cpu's two cores and the shared instruction/data RAM.
//  - Programming port owns the RAM while cpu_en=0; the cores are round-robin arbitrated while cpu_en=1.
// PARAMETERS
//  DATA_SIZE   32  memory word width
//  ADRS_SIZE   11  memory address width (matches w_adrs)
//  MEM_RD_LAT  1   RAM read latency in cycles, legal range 1..3
// PORTS
//  sys_clk      in   1          single clock; all state updates on the rising edge
//  reset        in   1          synchronous, active-high
//  cpu_en       in   1          1 = run mode (cores arbitrated), 0 = programming mode
//  w_enable     in   1          programming write strobe (honoured only when cpu_en=0)
//  w_adrs       in   ADRS_SIZE  programming address
//  w_instruction in  DATA_SIZE  programming write data
//  c0_req/c1_req      in   1          core access request, held until grant
//  c0_we/c1_we        in   1          1 = write, 0 = read (sampled at grant)
//  c0_adrs/c1_adrs    in   ADRS_SIZE  access address
//  c0_wdata/c1_wdata  in   DATA_SIZE  write data
//  c0_gnt/c1_gnt      out  1          one-cycle grant pulse; the request is consumed
//  c0_rvalid/c1_rvalid out 1          one-cycle read-data-valid pulse
//  c0_rdata/c1_rdata  out  DATA_SIZE  read data, valid with rvalid and held until the next rvalid
//  mem_en       out  1          RAM access strobe
//  mem_we       out  1          RAM write enable
//  mem_adrs     out  ADRS_SIZE  RAM address
//  mem_wdata    out  DATA_SIZE  RAM write data
//  mem_rdata    in   DATA_SIZE  RAM read data, MEM_RD_LAT cycles after mem_en
//  busy         out  1          arbiter is not in IDLE
// BEHAVIOUR
//  - Reset: every output 0; FSM goes to IDLE; the RR pointer favours core 0; the read-wait counter is cleared.
//    A reset mid-read drops the read and asserts no rvalid.
//  - FSM states: IDLE, ACCESS, RD_WAIT. All outputs are registered.
//    - IDLE -> ACCESS: cpu_en=1 and any creq.
//    - ACCESS -> IDLE: the granted access is a write.
//    - ACCESS -> RD_WAIT: the granted access is a read.
//    - RD_WAIT -> IDLE: after MEM_RD_LAT cycles, with rvalid pulsed to the owner.
//  - Grant selection, made in IDLE:
//    - Requester not favoured by the RR pointer wins only if the favoured one is idle.
//    - The pointer flips to the other core after every grant.
//  - ACCESS is a single cycle with these outputs:
//    - cN_gnt=1, mem_en=1, and mem_we/adrs/wdata taken from the winner.
//  - Read latency: from the gnt cycle to the rvalid cycle is MEM_RD_LAT+1 cycles.
//  - Write occupancy: a write occupies the RAM for 1 cycle.
//  - Back-to-back requests: after returning to IDLE, a new grant comes no earlier than the following cycle.
//    - Minimum spacing between grants: 2 cycles for writes, MEM_RD_LAT+2 cycles for reads.
//  - Simultaneous c0_req and c1_req: the pointer decides, so the cores alternate strictly under sustained contention.
//  - cpu_en=0 (programming mode):
//    - mem_en = mem_we = w_enable, mem_adrs = w_adrs, mem_wdata = w_instruction, registered with 1-cycle latency.
//    - No core grants are issued; core requests stay pending.
//  - cpu_en falling mid-transaction: the in-flight ACCESS/RD_WAIT completes normally, including rvalid.
//    Programming pass-through starts only from IDLE; w_enable writes seen while busy are dropped.
//  - cpu_en rising: arbitration starts the next cycle from IDLE; the pointer keeps its last value.
//  - Address and data are passed through unmodified; no wrap or width conversion is done.
// CONFIGURATION
//  - Macro ARB_STATS_EN.
//  - Defined:
//    - Adds outputs stall_cnt0 and stall_cnt1 (16 bit each).
//    - stall_cntN increments each cycle cN_req=1 without cN_gnt in run mode, saturates at 16'hffff, and is cleared by reset.
//  - Undefined: no ports, no counter logic; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package arb_pkg holds the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RD_WAIT=2'd2) and the CORE0/CORE1 owner IDs.
//  - One sub-module, rr_pick2: a 2-requester round-robin selector (req[1:0], ptr -> onehot gnt, next ptr), purely combinational.
// TESTING
//  1. Reset held 3 cycles with c0_req=1 -> all outputs 0 and no gnt until 1 cycle after reset drops.
//  2. cpu_en=0, w_enable=1, w_adrs=11'h0ff, w_instruction=32'hffffffff
//     -> next cycle mem_en=mem_we=1, mem_adrs=11'h0ff, mem_wdata=32'hffffffff; c0_req ignored.
//  3. cpu_en=1, c0 read at 11'h002, RAM returns 32'h0000008f
//     -> c0_gnt pulse, then c0_rvalid=1 with c0_rdata=32'h0000008f exactly MEM_RD_LAT+1 cycles later.
//  4. c0_req and c1_req both held high with writes for 6 grants -> grant order c0,c1,c0,c1,c0,c1, each ACCESS cycle separated by IDLE.
//  5. cpu_en drops during RD_WAIT of a c1 read
//     -> c1_rvalid still asserted; a w_enable pulse in the same cycle is dropped; the next w_enable is written.
//  6. With ARB_STATS_EN: c1 blocked for 4 cycles by c0 reads (MEM_RD_LAT=1) -> stall_cnt1 == 4 at c1_gnt.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// arb_pkg: FSM state encoding and core owner IDs shared by the arbiter files
package arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;
  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;
endpackage

// File: rtl/shared_mem_arbiter_if.sv
// shared_mem_arbiter_if: core, programming and RAM signals of the shared memory arbiter
interface shared_mem_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADRS_SIZE = 11
);
  logic                 cpu_en, w_enable;
  logic [ADRS_SIZE-1:0] w_adrs;
  logic [DATA_SIZE-1:0] w_instruction;
  logic                 c0_req, c1_req, c0_we, c1_we;
  logic [ADRS_SIZE-1:0] c0_adrs, c1_adrs;
  logic [DATA_SIZE-1:0] c0_wdata, c1_wdata;
  logic                 c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DATA_SIZE-1:0] c0_rdata, c1_rdata;
  logic                 mem_en, mem_we, busy;
  logic [ADRS_SIZE-1:0] mem_adrs;
  logic [DATA_SIZE-1:0] mem_wdata, mem_rdata;
  modport master (
    output cpu_en, w_enable, w_adrs, w_instruction,
    output c0_req, c1_req, c0_we, c1_we, c0_adrs, c1_adrs, c0_wdata, c1_wdata, mem_rdata,
    input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
    input  mem_en, mem_we, mem_adrs, mem_wdata, busy
  );
  modport slave (
    input  cpu_en, w_enable, w_adrs, w_instruction,
    input  c0_req, c1_req, c0_we, c1_we, c0_adrs, c1_adrs, c0_wdata, c1_wdata, mem_rdata,
    output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
    output mem_en, mem_we, mem_adrs, mem_wdata, busy
  );
endinterface

// File: rtl/shared_mem_arbiter_rr_pick2.sv
// rr_pick2: two-requester round-robin selector; ptr names the favoured requester
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       nxt_ptr
);
  always_comb begin
    gnt[0]  = req[0] & (~ptr | ~req[1]);
    gnt[1]  = req[1] & (ptr | ~req[0]);
    nxt_ptr = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : ptr;
  end
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin sharing of one RAM port between two cores and the host port; ARB_STATS_EN adds stall counters
module shared_mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADRS_SIZE  = 11,
  parameter int MEM_RD_LAT = 1
) (
  input logic sys_clk,
  input logic reset,
  shared_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt0,
  output logic [15:0] stall_cnt1
`endif
);
  state_t               state, nxt;
  logic                 ptr, own, nxt_ptr, sel, go, prog, rd_done;
  logic [1:0]           cnt, pick, gnt_d, rvalid_d;
  logic                 mem_en_d, mem_we_d;
  logic [ADRS_SIZE-1:0] mem_adrs_d;
  logic [DATA_SIZE-1:0] mem_wdata_d;

  rr_pick2 u_pick (
    .req    ({bus.c1_req, bus.c0_req}),
    .ptr    (ptr),
    .gnt    (pick),
    .nxt_ptr(nxt_ptr)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= CORE0;
      own   <= CORE0;
      cnt   <= 2'd0;
    end else begin
      state <= nxt;
      ptr   <= go ? nxt_ptr : ptr;
      own   <= go ? sel : own;
      cnt   <= state == RD_WAIT ? cnt + 2'd1 : 2'd0;
    end
  end

  // mem_we still holds the granted access type during ACCESS
  always_comb begin
    go      = state == IDLE && bus.cpu_en && |pick;
    rd_done = state == RD_WAIT && cnt == 2'(MEM_RD_LAT - 1);
    nxt     = go ? ACCESS
            : state == ACCESS ? (bus.mem_we ? IDLE : RD_WAIT)
            : state == RD_WAIT && !rd_done ? RD_WAIT : IDLE;
  end

  always_comb begin
    prog        = state == IDLE && !bus.cpu_en;
    sel         = pick[1];
    gnt_d       = go ? pick : 2'b00;
    mem_en_d    = go || (prog && bus.w_enable);
    mem_we_d    = go ? (sel ? bus.c1_we : bus.c0_we) : prog && bus.w_enable;
    mem_adrs_d  = go ? (sel ? bus.c1_adrs : bus.c0_adrs) : prog ? bus.w_adrs : bus.mem_adrs;
    mem_wdata_d = go ? (sel ? bus.c1_wdata : bus.c0_wdata) : prog ? bus.w_instruction : bus.mem_wdata;
    rvalid_d    = rd_done ? (own == CORE1 ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      {bus.c1_gnt, bus.c0_gnt}       <= 2'b00;
      {bus.c1_rvalid, bus.c0_rvalid} <= 2'b00;
      bus.c0_rdata                   <= '0;
      bus.c1_rdata                   <= '0;
      bus.mem_en                     <= 1'b0;
      bus.mem_we                     <= 1'b0;
      bus.mem_adrs                   <= '0;
      bus.mem_wdata                  <= '0;
      bus.busy                       <= 1'b0;
    end else begin
      {bus.c1_gnt, bus.c0_gnt}       <= gnt_d;
      {bus.c1_rvalid, bus.c0_rvalid} <= rvalid_d;
      bus.c0_rdata                   <= rvalid_d[0] ? bus.mem_rdata : bus.c0_rdata;
      bus.c1_rdata                   <= rvalid_d[1] ? bus.mem_rdata : bus.c1_rdata;
      bus.mem_en                     <= mem_en_d;
      bus.mem_we                     <= mem_we_d;
      bus.mem_adrs                   <= mem_adrs_d;
      bus.mem_wdata                  <= mem_wdata_d;
      bus.busy                       <= nxt != IDLE;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      stall_cnt0 <= 16'd0;
      stall_cnt1 <= 16'd0;
    end else begin
      if (bus.cpu_en && bus.c0_req && !bus.c0_gnt && stall_cnt0 != 16'hffff) stall_cnt0 <= stall_cnt0 + 16'd1;
      if (bus.cpu_en && bus.c1_req && !bus.c1_gnt && stall_cnt1 != 16'hffff) stall_cnt1 <= stall_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed and randomized checks of shared_mem_arbiter against a schedule-based model
module tb_shared_mem_arbiter;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.DATA_SIZE(32), .ADRS_SIZE(11)) bus ();
`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt0, stall_cnt1, s1;
`endif
  shared_mem_arbiter #(.DATA_SIZE(32), .ADRS_SIZE(11), .MEM_RD_LAT(LAT)) dut (
    .sys_clk(clk),
    .reset  (rst),
    .bus    (bus)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt0(stall_cnt0),
    .stall_cnt1(stall_cnt1)
`endif
  );

  logic        cpu_en, w_enable;
  logic [10:0] w_adrs;
  logic [31:0] w_instr, rdata_in;
  logic        req[2], we[2];
  logic [10:0] adrs[2];
  logic [31:0] wdata[2];
  assign bus.cpu_en        = cpu_en;
  assign bus.w_enable      = w_enable;
  assign bus.w_adrs        = w_adrs;
  assign bus.w_instruction = w_instr;
  assign bus.c0_req        = req[0];
  assign bus.c1_req        = req[1];
  assign bus.c0_we         = we[0];
  assign bus.c1_we         = we[1];
  assign bus.c0_adrs       = adrs[0];
  assign bus.c1_adrs       = adrs[1];
  assign bus.c0_wdata      = wdata[0];
  assign bus.c1_wdata      = wdata[1];
  assign bus.mem_rdata     = rdata_in;

  logic [31:0] ram[2048], ref_mem[2048], pipe[4];
  int checks = 0, errors = 0, cyc = 0;

  // model: the RAM is free again from cycle free_at; a read completes at rv_at
  int          free_at, rv_at, rv_own, ptr_m, first, got;
  logic [31:0] rv_data, rd_m[2];
  int          st_m[2];
  logic [1:0]  e_gnt, e_rvalid;
  logic        e_en, e_we, e_busy, prev;
  logic [10:0] e_adrs;
  logic [31:0] e_wdata;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got_v, exp_v);
    end
  endtask

  task automatic ram_step();
    for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (bus.mem_en && !bus.mem_we) ? ram[bus.mem_adrs] : $urandom;
    if (bus.mem_en && bus.mem_we) ram[bus.mem_adrs] = bus.mem_wdata;
    rdata_in = pipe[LAT];
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      e_gnt = 0; e_rvalid = 0; e_en = 0; e_we = 0; e_adrs = 0; e_wdata = 0; e_busy = 0;
      ptr_m = 0; free_at = cyc + 1; rv_at = -1;
      rd_m[0] = 0; rd_m[1] = 0; st_m[0] = 0; st_m[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (cpu_en && req[k] && !e_gnt[k] && st_m[k] < 65535) st_m[k]++;
      e_gnt = 0; e_rvalid = 0; e_en = 0; e_we = 0;
      if (cyc >= free_at) begin
        if (cpu_en && (req[0] || req[1])) begin
          w = (req[0] && req[1]) ? ptr_m : (req[1] ? 1 : 0);
          ptr_m = 1 - w;
          e_gnt[w] = 1'b1; e_en = 1'b1; e_we = we[w]; e_adrs = adrs[w]; e_wdata = wdata[w];
          if (we[w]) begin
            ref_mem[adrs[w]] = wdata[w];
            free_at = cyc + 2;
          end else begin
            free_at = cyc + 2 + LAT;
            rv_at = cyc + 2 + LAT; rv_own = w; rv_data = ref_mem[adrs[w]];
          end
        end else if (!cpu_en && w_enable) begin
          e_en = 1'b1; e_we = 1'b1; e_adrs = w_adrs; e_wdata = w_instr;
          ref_mem[w_adrs] = w_instr;
        end
      end
      if (cyc + 1 == rv_at) begin
        e_rvalid[rv_own] = 1'b1;
        rd_m[rv_own] = rv_data;
      end
      e_busy = cyc + 1 < free_at;
    end
  endtask

  task automatic tick();
    ram_step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("c0_gnt", bus.c0_gnt, e_gnt[0]);
    chk("c1_gnt", bus.c1_gnt, e_gnt[1]);
    chk("c0_rvalid", bus.c0_rvalid, e_rvalid[0]);
    chk("c1_rvalid", bus.c1_rvalid, e_rvalid[1]);
    chk("c0_rdata", bus.c0_rdata, rd_m[0]);
    chk("c1_rdata", bus.c1_rdata, rd_m[1]);
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_we", bus.mem_we, e_we);
    chk("busy", bus.busy, e_busy);
    if (e_en) begin
      chk("mem_adrs", bus.mem_adrs, e_adrs);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
    end
`ifdef ARB_STATS_EN
    chk("stall_cnt0", stall_cnt0, st_m[0]);
    chk("stall_cnt1", stall_cnt1, st_m[1]);
`endif
    for (int k = 0; k < 2; k++) if (e_gnt[k]) req[k] = 1'b0;
  endtask

  task automatic gen();
    rst = ($urandom_range(0, 249) == 0);
    if ($urandom_range(0, 19) == 0) cpu_en = !cpu_en;
    w_enable = 1'($urandom_range(0, 1));
    w_adrs   = 11'($urandom_range(0, 15));
    w_instr  = $urandom;
    for (int k = 0; k < 2; k++)
      if (!req[k] && $urandom_range(0, 2) == 0) begin
        req[k] = 1'b1; we[k] = 1'($urandom_range(0, 1));
        adrs[k] = 11'($urandom_range(0, 15)); wdata[k] = $urandom;
      end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 32'(i) * 32'h9e3779b9;
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
    ram[2] = 32'h0000008f; ref_mem[2] = 32'h0000008f;
    rdata_in = 0; cpu_en = 1; w_enable = 0; w_adrs = 0; w_instr = 0;
    for (int k = 0; k < 2; k++) begin req[k] = 0; we[k] = 0; adrs[k] = 0; wdata[k] = 0; end
    e_gnt = 0; e_rvalid = 0; e_en = 0; e_we = 0; e_busy = 0; e_adrs = 0; e_wdata = 0;
    free_at = 0; rv_at = -1; rv_own = 0; rv_data = 0; ptr_m = 0;
    rd_m[0] = 0; rd_m[1] = 0; st_m[0] = 0; st_m[1] = 0;

    // reset held 3 cycles with a pending c0 read of the 8f word
    rst = 1; req[0] = 1; we[0] = 0; adrs[0] = 11'h002;
    repeat (3) tick();
    rst = 0;
    chk("rst_release_gnt", bus.c0_gnt, 0);
    tick();
    chk("t1_gnt", bus.c0_gnt, 1);
    repeat (LAT + 1) tick();
    chk("t3_rvalid", bus.c0_rvalid, 1);
    chk("t3_rdata", bus.c0_rdata, 32'h0000008f);
    tick();

    // programming pass-through; the core request must stay pending
    cpu_en = 0; w_enable = 1; w_adrs = 11'h0ff; w_instr = 32'hffffffff;
    req[0] = 1; we[0] = 1; adrs[0] = 11'h005; wdata[0] = 32'h1;
    tick();
    chk("t2_en", bus.mem_en, 1);
    chk("t2_we", bus.mem_we, 1);
    chk("t2_adrs", bus.mem_adrs, 11'h0ff);
    chk("t2_wdata", bus.mem_wdata, 32'hffffffff);
    chk("t2_no_gnt", bus.c0_gnt, 0);
    w_enable = 0;
    repeat (3) tick();
    chk("t2_pending", bus.c0_gnt, 0);
    cpu_en = 1;
    repeat (4) tick();

    // sustained contention with writes alternates strictly
    first = ptr_m; got = 0; prev = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      for (int k = 0; k < 2; k++)
        if (!req[k]) begin
          req[k] = 1; we[k] = 1; adrs[k] = 11'(16 + 4 * k + got); wdata[k] = $urandom;
        end
      tick();
      if (bus.c0_gnt || bus.c1_gnt) begin
        chk("t4_order", {bus.c1_gnt, bus.c0_gnt}, ((first + got) % 2 == 1) ? 32'd2 : 32'd1);
        chk("t4_gap", prev, 0);
        got++;
      end
      prev = bus.c0_gnt | bus.c1_gnt;
    end
    chk("t4_count", got, 6);
    repeat (4) tick();

`ifdef ARB_STATS_EN
    req[1] = 1; we[1] = 1; adrs[1] = 11'h030; wdata[1] = $urandom;
    repeat (4) tick();
    s1 = stall_cnt1;
    req[0] = 1; we[0] = 0; adrs[0] = 11'h002;
    req[1] = 1; we[1] = 1; adrs[1] = 11'h031; wdata[1] = $urandom;
    for (int i = 0; i < 20 && !bus.c1_gnt; i++) tick();
    chk("t6_c1_gnt", bus.c1_gnt, 1);
    chk("t6_stall", 32'(stall_cnt1 - s1), LAT + 3);
    repeat (4) tick();
`endif

    // cpu_en drops while a c1 read is in RD_WAIT
    req[1] = 1; we[1] = 0; adrs[1] = 11'h005;
    for (int i = 0; i < 20 && !bus.c1_gnt; i++) tick();
    chk("t5_gnt", bus.c1_gnt, 1);
    tick();
    for (int i = 1; i <= LAT; i++) begin
      cpu_en = 0; w_enable = (i == 1); w_adrs = 11'h007; w_instr = 32'h12345678;
      tick();
    end
    chk("t5_rvalid", bus.c1_rvalid, 1);
    chk("t5_rdata", bus.c1_rdata, ref_mem[5]);
    chk("t5_dropped", bus.mem_en, 0);
    w_enable = 1; w_adrs = 11'h009; w_instr = 32'hcafef00d;
    tick();
    chk("t5_write_en", bus.mem_en, 1);
    chk("t5_write_adrs", bus.mem_adrs, 11'h009);
    w_enable = 0; cpu_en = 1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      gen();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
